universal_shift_register: RTL and testbench

Parametrised N-bit register generalising the plain parallel-load register with hold, parallel load, logical/arithmetic shifts and rotates, plus an autonomous N-cycle full-duplex serialise/deserialise transfer. It serves as the common storage/shift element behind serial links, bit-serial arithmetic and test shifting, driven by a simple mode/enable control interface.

---
 rtl/usr_pkg.sv | 20 ++
 rtl/usr_bit_counter.sv | 27 ++
 rtl/universal_shift_register.sv | 115 +++++++++++
 tb/tb_universal_shift_register.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: command encoding and transfer FSM states.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD      = 3'b000,
        MODE_LOAD      = 3'b001,
        MODE_SHL       = 3'b010,
        MODE_SHR       = 3'b011,
        MODE_ROL       = 3'b100,
        MODE_ROR       = 3'b101,
        MODE_ASR       = 3'b110,
        MODE_SERIALISE = 3'b111
    } usr_mode_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } usr_state_t;

endpackage

// File: rtl/usr_bit_counter.sv
// Loadable down-counter that tracks the remaining steps of a serial transfer.
module usr_bit_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/universal_shift_register.sv
// N-bit register with load, shifts, rotates and an autonomous N-cycle full-duplex transfer.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter  int unsigned N     = 8,
    localparam int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [2:0]   mode,
    input  logic [N-1:0] parallel_in,
    input  logic         serial_in,
    output logic [N-1:0] reg_out,
    output logic         serial_out,
    output logic         busy,
    output logic         done
);

    usr_state_t   state, state_next;
    logic [N-1:0] reg_next;
    logic         serial_next;
    logic         done_next;
    logic         busy_next;
    logic         cnt_load;
    logic         cnt_dec;
    logic         cnt_last;

    usr_bit_counter #(.CNT_W(CNT_W)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (CNT_W'(N)),
        .dec        (cnt_dec),
        .last       (cnt_last)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            reg_out    <= '0;
            serial_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            reg_out    <= reg_next;
            serial_out <= serial_next;
            busy       <= busy_next;
            done       <= done_next;
        end
    end

    // Datapath next-value mux and transfer sequencing
    always_comb begin
        state_next  = state;
        reg_next    = reg_out;
        serial_next = serial_out;
        done_next   = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (en) begin
                    case (usr_mode_t'(mode))
                        MODE_HOLD: ;
                        MODE_LOAD: reg_next = parallel_in;
                        MODE_SHL: begin
                            reg_next    = {reg_out[N-2:0], serial_in};
                            serial_next = reg_out[N-1];
                        end
                        MODE_SHR: begin
                            reg_next    = {serial_in, reg_out[N-1:1]};
                            serial_next = reg_out[0];
                        end
                        MODE_ROL: begin
                            reg_next    = {reg_out[N-2:0], reg_out[N-1]};
                            serial_next = reg_out[N-1];
                        end
                        MODE_ROR: begin
                            reg_next    = {reg_out[0], reg_out[N-1:1]};
                            serial_next = reg_out[0];
                        end
                        MODE_ASR: begin
                            reg_next    = {reg_out[N-1], reg_out[N-1:1]};
                            serial_next = reg_out[0];
                        end
                        MODE_SERIALISE: begin
                            reg_next   = parallel_in;
                            cnt_load   = 1'b1;
                            state_next = ST_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // LSB leaves on serial_out while serial_in fills from the top
                reg_next    = {serial_in, reg_out[N-1:1]};
                serial_next = reg_out[0];
                cnt_dec     = 1'b1;
                if (cnt_last) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next == ST_RUN);
    end

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised and directed checking of universal_shift_register against a behavioural model.
module tb_universal_shift_register;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic [N-1:0] parallel_in = '0;
    logic         serial_in = 1'b0;
    logic [N-1:0] reg_out;
    logic         serial_out;
    logic         busy;
    logic         done;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: register value, last ejected bit, and steps left in a transfer
    logic [N-1:0] m_reg = '0;
    logic         m_so = 1'b0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    int           m_left = 0;

    universal_shift_register #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .parallel_in (parallel_in),
        .serial_in   (serial_in),
        .reg_out     (reg_out),
        .serial_out  (serial_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [2:0] m,
                              input logic [N-1:0] pi, input logic si);
        logic [N-1:0] si_top;
        si_top = {si, {(N-1){1'b0}}};
        if (r) begin
            m_reg = '0; m_so = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_so   = m_reg[0];
            m_reg  = (m_reg >> 1) | si_top;
            m_left = m_left - 1;
            m_done = (m_left == 0);
            m_busy = (m_left != 0);
        end else begin
            m_done = 1'b0;
            if (e) begin
                case (m)
                    3'd1: m_reg = pi;
                    3'd2: begin m_so = m_reg[N-1]; m_reg = (m_reg << 1) | N'(si); end
                    3'd3: begin m_so = m_reg[0];   m_reg = (m_reg >> 1) | si_top; end
                    3'd4: begin m_so = m_reg[N-1]; m_reg = (m_reg << 1) | (m_reg >> (N-1)); end
                    3'd5: begin m_so = m_reg[0];   m_reg = (m_reg >> 1) | (m_reg << (N-1)); end
                    3'd6: begin m_so = m_reg[0];   m_reg = N'($signed(m_reg) >>> 1); end
                    3'd7: begin m_reg = pi; m_left = N; m_busy = 1'b1; end
                    default: ;
                endcase
            end
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [N-1:0] pi, input logic si);
        reset = r; en = e; mode = m; parallel_in = pi; serial_in = si;
        @(posedge clk);
        model_edge(r, e, m, pi, si);
        #1;
        check("reg_out",    32'(reg_out),    32'(m_reg));
        check("serial_out", 32'(serial_out), 32'(m_so));
        check("busy",       32'(busy),       32'(m_busy));
        check("done",       32'(done),       32'(m_done));
    endtask

    initial begin
        logic [7:0] si_seq;
        logic [7:0] so_exp;
        int busy_cnt;
        int done_cnt;

        // Reset and reset-after-load
        step(1'b1, 1'b0, 3'd0, '0, 1'b0);
        step(1'b0, 1'b1, 3'd1, 8'hA5, 1'b0);
        check("load_a5", 32'(reg_out), 32'h0000_00A5);
        step(1'b1, 1'b1, 3'd1, 8'hFF, 1'b1);
        check("rst_reg", 32'(reg_out), 32'h0);
        check("rst_bsy", 32'({serial_out, busy, done}), 32'h0);

        // Rotates and arithmetic shift
        step(1'b0, 1'b1, 3'd1, 8'h81, 1'b0);
        step(1'b0, 1'b1, 3'd4, 8'h00, 1'b0);
        check("rol", 32'({serial_out, reg_out}), 32'h0000_0103);
        step(1'b0, 1'b1, 3'd5, 8'h00, 1'b0);
        check("ror", 32'(reg_out), 32'h0000_0081);
        step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0);
        check("asr", 32'({serial_out, reg_out}), 32'h0000_01C0);

        // Logical shifts; en=0 holds regardless of mode
        step(1'b0, 1'b1, 3'd1, 8'h0F, 1'b0);
        step(1'b0, 1'b1, 3'd2, 8'h00, 1'b1);
        check("shl", 32'({serial_out, reg_out}), 32'h0000_001F);
        step(1'b0, 1'b1, 3'd3, 8'h00, 1'b0);
        check("shr", 32'({serial_out, reg_out}), 32'h0000_010F);
        step(1'b0, 1'b0, 3'd7, 8'hEE, 1'b1);
        check("en_low_hold", 32'({busy, reg_out}), 32'h0000_000F);

        // Full-duplex transfer of 0xB4 with a LOAD attempted mid-transfer
        si_seq = 8'b0110_0101;   // bit k is the k-th serial_in bit: 1,0,1,0,0,1,1,0
        so_exp = 8'b1011_0100;   // bit k is the expected serial_out after shift k+1
        busy_cnt = 0; done_cnt = 0;
        step(1'b0, 1'b1, 3'd7, 8'hB4, 1'b0);
        if (busy) busy_cnt++;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) step(1'b0, 1'b1, 3'd1, 8'hFF, si_seq[k]);
            else        step(1'b0, 1'b0, 3'd0, 8'h00, si_seq[k]);
            check("ser_so", 32'(serial_out), 32'(so_exp[k]));
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        check("ser_reg", 32'(reg_out), 32'h0000_0065);
        check("ser_done", 32'(done), 32'h1);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        if (done) done_cnt++;
        check("ser_busy_cycles", 32'(busy_cnt), 32'd8);
        check("ser_done_pulses", 32'(done_cnt), 32'd1);

        // Back-to-back: second SERIALISE issued in the done cycle
        step(1'b0, 1'b1, 3'd7, 8'h3C, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        check("b2b_done", 32'(done), 32'h1);
        step(1'b0, 1'b1, 3'd7, 8'hC3, 1'b0);
        check("b2b_accept", 32'({busy, reg_out}), 32'h0000_01C3);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        check("b2b_first_bit", 32'(serial_out), 32'h1);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        check("b2b_done2", 32'(done), 32'h1);

        // Reset at the fourth shift aborts the transfer without a done pulse
        step(1'b0, 1'b1, 3'd7, 8'h5A, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
        check("abort_state", 32'({reg_out, serial_out, busy, done}), 32'h0);
        step(1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
        check("abort_no_done", 32'(done), 32'h0);
        step(1'b0, 1'b1, 3'd7, 8'h99, 1'b0);
        check("restart_busy", 32'(busy), 32'h1);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 3'd0, 8'h00, 1'b1);
        check("restart_done", 32'({done, reg_out}), 32'h0000_01FF);

        // Randomised traffic, including occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom), 3'($urandom),
                 N'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
